// File: rtl/pool_ctrl.sv
// -----------------------------------------------------------------------------
// pool_ctrl
//
// Sequencer for a 2x2 max-pool compare unit. A raster-order stream of signed
// conv results enters through in_valid/in_data/in_ready. Every even row is
// stored in a line buffer. On the following odd row each pair of columns forms
// one 2x2 window, issued to the compare unit as two column words with a
// one-cycle pool_valid strobe. Results coming back on cmp_valid/cmp_data are
// registered to out_valid/out_data and counted. Once every pooled pixel of
// the frame has come back, frame_done pulses for one cycle.
//
// Ports
//   clk        in   clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle frame start, honoured only when idle
//   in_valid   in   input pixel valid
//   in_data    in   DATA_W signed input pixel
//   in_ready   out  pixel accepted when in_valid && in_ready
//   pool_valid out  one-cycle window strobe to the compare unit
//   pool_x1    out  left column  {top, bottom}, top in the upper DATA_W bits
//   pool_x2    out  right column {top, bottom}
//   cmp_valid  in   compare unit result valid
//   cmp_data   in   DATA_W signed maximum from the compare unit
//   out_valid  out  pooled pixel valid
//   out_data   out  DATA_W pooled pixel
//   busy       out  frame in progress (start accepted, frame_done not yet)
//   frame_done out  one-cycle pulse after the last pooled pixel
//
// Optional feature: define POOL_CTRL_RELU_EN to clamp negative pooled pixels
// to zero on out_data. Default build passes cmp_data through unchanged.
// -----------------------------------------------------------------------------
module pool_ctrl #(
  parameter int DATA_W = 22,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24,
  parameter int COL_W  = 5,
  parameter int ROW_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     pool_valid,
  output logic [2*DATA_W-1:0]      pool_x1,
  output logic [2*DATA_W-1:0]      pool_x2,
  input  logic                     cmp_valid,
  input  logic signed [DATA_W-1:0] cmp_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int CNT_W = COL_W + ROW_W;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  // Row counter holds the index of the even row of the current row pair.
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 2);
  localparam logic [CNT_W-1:0] RES_TOTAL = CNT_W'((IMG_W / 2) * (IMG_H / 2));

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVEN,
    S_ODD,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [COL_W-1:0]           col_q, col_d;
  logic [ROW_W-1:0]           row_q, row_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic signed [DATA_W-1:0]   bot_left_q, bot_left_d;
  logic                       pool_valid_q, pool_valid_d;
  logic [2*DATA_W-1:0]        pool_x1_q, pool_x1_d;
  logic [2*DATA_W-1:0]        pool_x2_q, pool_x2_d;
  logic                       out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0]   out_data_q, out_data_d;

  logic [DATA_W-1:0]          linebuf_q [IMG_W];

  logic                       accept;
  logic [COL_W-1:0]           col_even;
  logic [DATA_W-1:0]          top_left;
  logic [DATA_W-1:0]          top_right;

  assign in_ready   = (state_q == S_EVEN) || (state_q == S_ODD);
  assign busy       = in_ready || (state_q == S_DRAIN);
  assign frame_done = (state_q == S_DONE);
  assign accept     = in_valid && in_ready;

  // Top row of the current window: the even column of the pair and the
  // column under the current pixel.
  assign col_even  = col_q & ~COL_W'(1);
  assign top_left  = linebuf_q[col_even];
  assign top_right = linebuf_q[col_q];

  assign pool_valid = pool_valid_q;
  assign pool_x1    = pool_x1_q;
  assign pool_x2    = pool_x2_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a variable unassigned and no latch is inferred.
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    cnt_d        = cnt_q;
    bot_left_d   = bot_left_q;
    pool_valid_d = 1'b0;
    pool_x1_d    = pool_x1_q;
    pool_x2_d    = pool_x2_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;

    // Results may arrive while later rows still stream or while draining;
    // outside a frame they are dropped.
    if (busy && cmp_valid) begin
      cnt_d       = cnt_q + CNT_W'(1);
      out_valid_d = 1'b1;
`ifdef POOL_CTRL_RELU_EN
      out_data_d  = cmp_data[DATA_W-1] ? '0 : cmp_data;
`else
      out_data_d  = cmp_data;
`endif
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_EVEN;
          col_d   = '0;
          row_d   = '0;
          cnt_d   = '0;
        end
      end

      S_EVEN: begin
        if (accept) begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = S_ODD;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end

      S_ODD: begin
        if (accept) begin
          if (!col_q[0]) begin
            bot_left_d = in_data;
          end else begin
            pool_valid_d = 1'b1;
            pool_x1_d    = {top_left, bot_left_q};
            pool_x2_d    = {top_right, in_data};
          end
          if (col_q == COL_LAST) begin
            col_d   = '0;
            row_d   = row_q + ROW_W'(2);
            state_d = (row_q == ROW_LAST) ? S_DRAIN : S_EVEN;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end

      // The registered count is compared, so a result arriving on the cycle
      // the count completes is counted first and DONE follows a cycle later.
      S_DRAIN: begin
        if (cnt_q == RES_TOTAL) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      cnt_q        <= '0;
      bot_left_q   <= '0;
      pool_valid_q <= 1'b0;
      pool_x1_q    <= '0;
      pool_x2_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      bot_left_q   <= bot_left_d;
      pool_valid_q <= pool_valid_d;
      pool_x1_q    <= pool_x1_d;
      pool_x2_q    <= pool_x2_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  // NOTE: the line buffer is deliberately not reset; each entry is written
  // during the even row before the odd row reads it, so stale contents are
  // never used and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (state_q == S_EVEN && accept) begin
      linebuf_q[col_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_pool_ctrl.sv
module tb_pool_ctrl;

  localparam int DW   = 22;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int NWIN = (W / 2) * (H / 2);

  typedef struct packed {
    logic [NPIX-1:0][DW-1:0] pix;
    logic [NWIN-1:0][DW-1:0] exp_plain;
    logic [NWIN-1:0][DW-1:0] exp_relu;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ready;
  logic                 pool_valid;
  logic [2*DW-1:0]      pool_x1;
  logic [2*DW-1:0]      pool_x2;
  logic                 cmp_valid = 1'b0;
  logic signed [DW-1:0] cmp_data  = '0;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic                 busy;
  logic                 frame_done;

  int n_total = 0;
  int n_bad   = 0;

  // Observed traffic
  logic [4*DW-1:0] win_q [$];
  int              out_q [$];
  int              done_cnt = 0;
  logic            prev_acc = 1'b0;

  // Compare-unit emulation: result returned two cycles after pool_valid
  logic                 seen_v = 1'b0;
  logic signed [DW-1:0] seen_d = '0;
  logic                 pipe_v = 1'b0;
  logic signed [DW-1:0] pipe_d = '0;
  logic                 inj_v  = 1'b0;
  logic signed [DW-1:0] inj_d  = '0;

  // Current frame and its expected results
  int   cur_pix [NPIX];
  int   cur_exp [NWIN];
  vec_t vecs [3];

  int p0 [NPIX] = '{1, 5, -3, 2, 4, 0, 7, -8, -1, -2, -3, -4, -5, -6, -7, -9};
  int e0 [NWIN] = '{5, 7, -1, -3};
  int r0 [NWIN] = '{5, 7, 0, 0};
  int p1 [NPIX] = '{-2097152, -2097152, 2097151, 0,
                    -2097152, -2097151, -1, -2,
                    0, 0, 0, 0,
                    -2097152, 0, 0, 0};
  int e1 [NWIN] = '{-2097151, 2097151, 0, 0};
  int r1 [NWIN] = '{0, 2097151, 0, 0};
  int p2 [NPIX] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
  int e2 [NWIN] = '{6, 8, 14, 16};
  int r2 [NWIN] = '{6, 8, 14, 16};

  pool_ctrl #(
    .DATA_W(DW), .IMG_W(W), .IMG_H(H), .COL_W(2), .ROW_W(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .pool_valid(pool_valid),
    .pool_x1   (pool_x1),
    .pool_x2   (pool_x2),
    .cmp_valid (cmp_valid),
    .cmp_data  (cmp_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4*DW-1:0] got,
                       input logic [4*DW-1:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic signed [DW-1:0] max4(input logic [2*DW-1:0] a,
                                                input logic [2*DW-1:0] b);
    logic signed [DW-1:0] v [4];
    logic signed [DW-1:0] m;
    v[0] = a[2*DW-1:DW];
    v[1] = a[DW-1:0];
    v[2] = b[2*DW-1:DW];
    v[3] = b[DW-1:0];
    m = v[0];
    for (int i = 1; i < 4; i++) if (v[i] > m) m = v[i];
    return m;
  endfunction

  // Reference model: window geometry straight from the frame array.
  function automatic int px(input int r, input int c);
    return cur_pix[r * W + c];
  endfunction

  function automatic logic [4*DW-1:0] model_win(input int w);
    int r;
    int c;
    r = 2 * (w / (W / 2));
    c = 2 * (w % (W / 2));
    return {DW'(px(r, c)), DW'(px(r + 1, c)), DW'(px(r, c + 1)), DW'(px(r + 1, c + 1))};
  endfunction

  function automatic int model_res(input int w);
    int r;
    int c;
    int m;
    r = 2 * (w / (W / 2));
    c = 2 * (w % (W / 2));
    m = px(r, c);
    if (px(r + 1, c) > m)     m = px(r + 1, c);
    if (px(r, c + 1) > m)     m = px(r, c + 1);
    if (px(r + 1, c + 1) > m) m = px(r + 1, c + 1);
`ifdef POOL_CTRL_RELU_EN
    if (m < 0) m = 0;
`endif
    return m;
  endfunction

  function automatic vec_t mk_vec(input int p [NPIX], input int e [NWIN], input int r [NWIN]);
    vec_t v;
    for (int i = 0; i < NPIX; i++) v.pix[i] = DW'(p[i]);
    for (int i = 0; i < NWIN; i++) begin
      v.exp_plain[i] = DW'(e[i]);
      v.exp_relu[i]  = DW'(r[i]);
    end
    return v;
  endfunction

  task automatic load_vec(input int v);
    for (int i = 0; i < NPIX; i++) cur_pix[i] = $signed(vecs[v].pix[i]);
    for (int i = 0; i < NWIN; i++) begin
`ifdef POOL_CTRL_RELU_EN
      cur_exp[i] = $signed(vecs[v].exp_relu[i]);
`else
      cur_exp[i] = $signed(vecs[v].exp_plain[i]);
`endif
    end
  endtask

  task automatic load_rand();
    for (int i = 0; i < NPIX; i++) begin
      if ($urandom_range(0, 3) == 0) cur_pix[i] = int'($urandom_range(0, 6)) - 3;
      else                           cur_pix[i] = $signed(DW'($urandom));
    end
    for (int i = 0; i < NWIN; i++) cur_exp[i] = model_res(i);
  endtask

  // Compare unit: drives its result two cycles after the window strobe.
  always @(posedge clk) begin
    #2;
    cmp_valid = pipe_v | inj_v;
    cmp_data  = inj_v ? inj_d : pipe_d;
    pipe_v    = seen_v;
    pipe_d    = seen_d;
  end

  // Monitor, sampled mid-cycle.
  always @(negedge clk) begin
    seen_v = pool_valid;
    seen_d = max4(pool_x1, pool_x2);
    if (pool_valid) begin
      win_q.push_back({pool_x1, pool_x2});
      check("pool_valid only after an accepting beat", {87'd0, prev_acc}, 1);
    end
    if (out_valid) out_q.push_back(int'(out_data));
    if (frame_done) begin
      done_cnt++;
      check("busy low with frame_done", {87'd0, busy}, 0);
      check("in_ready low in DONE", {87'd0, in_ready}, 0);
    end
    prev_acc = in_valid && in_ready;
  end

  // Called at posedge+1; returns at posedge+1 after the last accept.
  task automatic stream(input int n, input bit gaps, input int restart_at);
    int k;
    int cyc;
    k   = 0;
    cyc = 0;
    while (k < n && cyc < 50 * n) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = DW'(cur_pix[k]);
      start    = (k == restart_at);
      @(negedge clk);
      if (in_valid && in_ready) k++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("stream pixels accepted", k, n);
  endtask

  task automatic run_frame(input string tag, input bit gaps, input int restart_at,
                           input int tail);
    int cyc;
    win_q.delete();
    out_q.delete();
    done_cnt = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stream(NPIX, gaps, restart_at);
    cyc = 0;
    @(negedge clk);
    while (!frame_done && cyc < 100) begin
      check({tag, " in_ready low in DRAIN"}, {87'd0, in_ready}, 0);
      @(negedge clk);
      cyc++;
    end
    check({tag, " frame_done seen"}, {87'd0, frame_done}, 1);
    @(posedge clk);
    #1;
    repeat (tail) begin
      @(posedge clk);
      #1;
    end
    check({tag, " window count"}, win_q.size(), NWIN);
    for (int w = 0; w < NWIN && w < win_q.size(); w++)
      check($sformatf("%s window %0d", tag, w), win_q[w], model_win(w));
    check({tag, " result count"}, out_q.size(), NWIN);
    for (int w = 0; w < NWIN && w < out_q.size(); w++)
      check($sformatf("%s result %0d", tag, w), out_q[w], cur_exp[w]);
    check({tag, " frame_done count"}, done_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    vecs[0]  = mk_vec(p0, e0, r0);
    vecs[1]  = mk_vec(p1, e1, r1);
    vecs[2]  = mk_vec(p2, e2, r2);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset pool_x1", pool_x1, 0);
    check("reset pool_x2", pool_x2, 0);
    check("reset out_data", out_data, 0);

    // Idle with start held low
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle outputs", {in_ready, pool_valid, busy, out_valid, frame_done}, 0);
    end
    @(posedge clk);
    #1;

    // Result while idle is dropped
    out_q.delete();
    inj_d = 22'sd7;
    inj_v = 1'b1;
    @(posedge clk);
    #1;
    inj_v = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("idle cmp_valid ignored", out_q.size(), 0);

    // Table-driven frames
    for (int v = 0; v < 3; v++) begin
      load_vec(v);
      run_frame($sformatf("vec%0d", v), 1'b0, -1, 0);
    end

    // Spec frame with random stalls
    load_vec(0);
    run_frame("vec0 stalls", 1'b1, -1, 0);

    // Random frames with random stalls
    for (int f = 0; f < 4; f++) begin
      load_rand();
      run_frame($sformatf("rand%0d", f), 1'b1, -1, 0);
    end

    // start pulsed mid-frame
    load_vec(2);
    run_frame("restart", 1'b0, 5, 10);

    // Reset after 6 pixels, then a fresh frame
    load_vec(0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stream(6, 1'b0, -1);
    rst = 1'b1;
    out_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    check("abort leaves no output", out_q.size(), 0);
    check("abort returns idle", {87'd0, busy}, 0);
    load_rand();
    run_frame("after abort", 1'b0, -1, 0);

    // Back-to-back frames, second start right after frame_done
    load_vec(1);
    run_frame("b2b first", 1'b0, -1, 0);
    load_rand();
    run_frame("b2b second", 1'b1, -1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
